// File: rtl/async_fifo_wr_framer.sv
// Write-side framer for ASYNC_FIFO. A 2-entry skid buffer feeds one output register, and the
// framer appends one trailer word holding the payload beat count after the last beat of each packet.
module async_fifo_wr_framer #(
  parameter int DATA_SIZE = 12,
  parameter int CNT_W     = 16
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_last,
  input  logic                 wFull,
  output logic                 winc,
  output logic [DATA_SIZE-1:0] wData,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

  state_t               state, stateNext;
  logic                 outValid, outLast, outLastNext;
  logic [DATA_SIZE-1:0] wDataNext;
  logic [DATA_SIZE-1:0] skData0, skData1;
  logic                 skLast0, skLast1;
  logic [1:0]           skCnt, skCntNext;
  logic [DATA_SIZE-1:0] beatCnt, beatCntNext, beatInc;
  logic [DATA_SIZE-1:0] trlVal, trlValNext;
  logic                 accept, stageFree, loadTrl, loadBypass, push, pop;
  logic [DATA_SIZE-1:0] srcData;
  logic                 srcLast;

  // outValid is kept as its own flop so that winc is a plain AND of two registers
  assign winc = outValid && !wFull;
  assign busy = outValid || (skCnt != 2'd0);

  always_comb begin
    accept      = in_valid && in_ready;
    stageFree   = !outValid || winc;
    loadTrl     = winc && outLast;
    pop         = stageFree && !loadTrl && (skCnt != 2'd0);
    loadBypass  = stageFree && !loadTrl && (skCnt == 2'd0) && accept;
    push        = accept && !loadBypass;
    srcData     = loadBypass ? in_data : skData0;
    srcLast     = loadBypass ? in_last : skLast0;
    beatInc     = (beatCnt == '1) ? beatCnt : beatCnt + 1'b1;
    skCntNext   = skCnt + {1'b0, push} - {1'b0, pop};
    stateNext   = state;
    wDataNext   = wData;
    outLastNext = outLast;
    beatCntNext = beatCnt;
    trlValNext  = trlVal;
    if (stageFree) begin
      if (loadTrl) begin
        stateNext   = TRAILER;
        wDataNext   = trlVal;
        outLastNext = 1'b0;
      end else if (pop || loadBypass) begin
        stateNext   = PAYLOAD;
        wDataNext   = srcData;
        outLastNext = srcLast;
        // The count is captured as the last beat enters, so the next packet can start counting at once
        if (srcLast) begin
          trlValNext  = beatInc;
          beatCntNext = '0;
        end else begin
          beatCntNext = beatInc;
        end
      end else begin
        stateNext   = IDLE;
        outLastNext = 1'b0;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst) begin
      state    <= IDLE;
      outValid <= 1'b0;
      outLast  <= 1'b0;
      wData    <= '0;
      skCnt    <= 2'd0;
      skData0  <= '0;
      skData1  <= '0;
      skLast0  <= 1'b0;
      skLast1  <= 1'b0;
      beatCnt  <= '0;
      trlVal   <= '0;
      pkt_cnt  <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= stateNext;
      outValid <= (stateNext != IDLE);
      outLast  <= outLastNext;
      wData    <= wDataNext;
      skCnt    <= skCntNext;
      beatCnt  <= beatCntNext;
      trlVal   <= trlValNext;
      in_ready <= (skCntNext < 2'd2);
      if (winc && state == TRAILER) pkt_cnt <= pkt_cnt + 1'b1;
      if (pop && push) begin
        if (skCnt == 2'd1) begin
          skData0 <= in_data;
          skLast0 <= in_last;
        end else begin
          skData0 <= skData1;
          skLast0 <= skLast1;
          skData1 <= in_data;
          skLast1 <= in_last;
        end
      end else if (pop) begin
        skData0 <= skData1;
        skLast0 <= skLast1;
      end else if (push) begin
        if (skCnt == 2'd0) begin
          skData0 <= in_data;
          skLast0 <= in_last;
        end else begin
          skData1 <= in_data;
          skLast1 <= in_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_framer.sv
// Self-checking bench for async_fifo_wr_framer: cycle table, directed corner cases, random scoreboard.
module tb_async_fifo_wr_framer;

  logic        wclk = 1'b0;
  logic        wrst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, wFull = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, winc, busy;
  logic [11:0] wData;
  logic [15:0] pkt_cnt;

  logic        in_valid4 = 1'b0, in_last4 = 1'b0, wFull4 = 1'b0;
  logic [3:0]  in_data4 = '0;
  logic        in_ready4, winc4, busy4;
  logic [3:0]  wData4;
  logic [15:0] pkt_cnt4;

  always #5 wclk = ~wclk;

  async_fifo_wr_framer dut (
    .wclk(wclk), .wrst(wrst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .wFull(wFull), .winc(winc), .wData(wData), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  async_fifo_wr_framer #(.DATA_SIZE(4)) dut4 (
    .wclk(wclk), .wrst(wrst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_last(in_last4), .wFull(wFull4), .winc(winc4), .wData(wData4), .pkt_cnt(pkt_cnt4), .busy(busy4)
  );

  int errors = 0;
  int checks = 0;
  logic [11:0] expQ[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Write monitor for the 12-bit instance: every FIFO write must match the expected queue
  always @(negedge wclk) begin
    if (wrst && winc) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL write-extra: got %h, required no write", wData);
      end else begin
        logic [11:0] e;
        e = expQ.pop_front();
        if (wData !== e) begin
          errors++;
          $display("FAIL write-data: got %h, required %h", wData, e);
        end
      end
    end
  end

  // All tasks start and end at #1 after a rising edge
  task automatic applyReset(input int n);
    wrst = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
    @(posedge wclk); #1;
    wFull = 1'b0; wFull4 = 1'b0;
    repeat (n) @(posedge wclk);
    #1;
    wrst = 1'b1;
    expQ.delete();
    @(posedge wclk); #1;
  endtask

  task automatic sendBeat(input logic [11:0] d, input logic l);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge wclk);
      got = in_ready;
      @(posedge wclk); #1;
      if (got) break;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send-timeout: got no in_ready, required accept of %h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      @(posedge wclk); #1;
    end
    chk("drain-busy", busy, 0);
  endtask

  typedef struct {
    logic v; logic [11:0] d; logic l; logic full;
    logic eWinc; logic [11:0] eData; logic chkD; logic eRdy; logic eBusy; logic [15:0] ePkt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // T2 then T4, absolute pkt_cnt values
    tbl[0]  = '{1'b1, 12'h111, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 12'h222, 1'b0, 1'b0, 1'b1, 12'h111, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 12'h333, 1'b1, 1'b0, 1'b1, 12'h222, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[3]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h333, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 1'b1, 1'b1, 16'd0};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 12'hABC, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 12'hDEF, 1'b1, 1'b0, 1'b1, 12'hABC, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'hDEF, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b1, 16'd2};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 16'd3};

    // T1: reset held with traffic offered
    wrst = 1'b0; in_valid = 1'b1; in_data = 12'h3AA; wFull = 1'b0;
    repeat (10) begin
      @(posedge wclk);
      @(negedge wclk);
      chk("rst-winc", winc, 0);
      chk("rst-ready", in_ready, 0);
      chk("rst-pkt", pkt_cnt, 0);
    end
    chk("rst-wdata", wData, 0);
    chk("rst-busy", busy, 0);
    @(posedge wclk); #1;
    in_valid = 1'b0; wrst = 1'b1;
    @(negedge wclk);
    chk("rel-ready-0", in_ready, 0);
    @(posedge wclk); #1;
    chk("rel-ready-1", in_ready, 1);

    // T2/T4 table
    expQ.delete();
    expQ.push_back(12'h111); expQ.push_back(12'h222); expQ.push_back(12'h333); expQ.push_back(12'h003);
    expQ.push_back(12'hABC); expQ.push_back(12'h001); expQ.push_back(12'hDEF); expQ.push_back(12'h001);
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l; wFull = tbl[i].full;
      @(negedge wclk);
      chk($sformatf("tbl%0d-winc", i), winc, tbl[i].eWinc);
      if (tbl[i].chkD) chk($sformatf("tbl%0d-wdata", i), wData, tbl[i].eData);
      chk($sformatf("tbl%0d-ready", i), in_ready, tbl[i].eRdy);
      chk($sformatf("tbl%0d-busy", i), busy, tbl[i].eBusy);
      chk($sformatf("tbl%0d-pkt", i), pkt_cnt, tbl[i].ePkt);
      @(posedge wclk); #1;
    end
    chk("tbl-queue-empty", expQ.size(), 0);

    // T3: wFull held for 5 cycles mid-packet, rising with an accept
    applyReset(3);
    for (int b = 0; b < 6; b++) expQ.push_back(12'(12'h101 + b));
    expQ.push_back(12'h006);
    begin
      int bi;
      bi = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
        wFull = (cyc >= 1 && cyc <= 5);
        if (bi < 6) begin
          in_valid = 1'b1; in_data = 12'(12'h101 + bi); in_last = (bi == 5);
        end else in_valid = 1'b0;
        @(negedge wclk);
        if (cyc >= 1 && cyc <= 5) begin
          chk("t3-full-winc", winc, 0);
          chk("t3-full-wdata", wData, 12'h101);
        end
        if (cyc >= 3 && cyc <= 5) chk("t3-full-ready", in_ready, 0);
        if (in_valid && in_ready) bi++;
        @(posedge wclk); #1;
        if (bi == 6 && !busy) break;
      end
      in_valid = 1'b0;
    end
    chk("t3-queue-empty", expQ.size(), 0);
    chk("t3-pkt", pkt_cnt, 1);

    // T5: 4-bit instance, 20-beat packet saturates the trailer
    applyReset(2);
    begin
      int bi, wi;
      logic [3:0] exp4[21];
      for (int i = 0; i < 20; i++) exp4[i] = 4'(i + 1);
      exp4[20] = 4'hF;
      bi = 0; wi = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
        if (bi < 20) begin
          in_valid4 = 1'b1; in_data4 = 4'(bi + 1); in_last4 = (bi == 19);
        end else in_valid4 = 1'b0;
        @(negedge wclk);
        if (winc4) begin
          if (wi < 21) chk($sformatf("t5-word%0d", wi), wData4, exp4[wi]);
          else chk("t5-extra-write", 1, 0);
          wi++;
        end
        if (in_valid4 && in_ready4) bi++;
        @(posedge wclk); #1;
        if (bi == 20 && !busy4) break;
      end
      in_valid4 = 1'b0;
      chk("t5-write-count", wi, 21);
      chk("t5-pkt", pkt_cnt4, 1);
    end

    // T6: reset mid-packet discards the partial packet without a trailer
    applyReset(2);
    wFull = 1'b1;
    sendBeat(12'h007, 1'b0);
    sendBeat(12'h008, 1'b0);
    chk("t6-busy-before-rst", busy, 1);
    applyReset(2);
    expQ.push_back(12'h005); expQ.push_back(12'h006); expQ.push_back(12'h002);
    sendBeat(12'h005, 1'b0);
    sendBeat(12'h006, 1'b1);
    drain();
    chk("t6-queue-empty", expQ.size(), 0);
    chk("t6-pkt", pkt_cnt, 1);

    // Random: 10k beats, packets of 1..8 beats, random wFull and valid gaps
    applyReset(2);
    begin
      int presented, pos, plen, pkts;
      logic acc;
      presented = 0; pos = 0; pkts = 0; acc = 1'b0;
      plen = $urandom_range(1, 8);
      for (int cyc = 0; cyc < 60000; cyc++) begin
        wFull = ($urandom_range(0, 9) < 3);
        if (acc || !in_valid) begin
          if (!(presented >= 10000 && pos == 0) && $urandom_range(0, 3) != 0) begin
            pos++; presented++;
            in_valid = 1'b1; in_data = 12'($urandom); in_last = (pos == plen);
          end else in_valid = 1'b0;
        end
        @(negedge wclk);
        acc = in_valid && in_ready;
        if (acc) begin
          expQ.push_back(in_data);
          if (in_last) begin
            expQ.push_back(12'(pos));
            pkts++; pos = 0;
            plen = $urandom_range(1, 8);
          end
        end
        @(posedge wclk); #1;
        if (presented >= 10000 && pos == 0) break;
      end
      in_valid = 1'b0; wFull = 1'b0;
      drain();
      chk("rnd-queue-empty", expQ.size(), 0);
      chk("rnd-pkt", pkt_cnt, 16'(pkts));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
